// File: rtl/usb4_scr_descr_multilane_pkg.sv
// usb4_scr_pkg: shared constants and the unrolled LFSR step function for the
// USB4 23-bit scrambler/descrambler (Fibonacci form, x^23+x^21+x^16+x^8+x^5+x^2+1).
// Content: LFSR_W, SCR_SEED_DEFAULT, tap indices, lfsr_adv() which returns the
// state after nbits steps plus the keystream bits produced on the way
// (keystream bit k = state[22] after k steps).
package usb4_scr_pkg;

    localparam int              LFSR_W           = 23;
    localparam logic [LFSR_W-1:0] SCR_SEED_DEFAULT = 23'h1FEEDD;
    localparam int              KS_MAX           = 32;

    // Output tap and feedback taps
    localparam int TAP_OUT = 22;
    localparam int TAP_A   = 20;
    localparam int TAP_B   = 15;
    localparam int TAP_C   = 7;
    localparam int TAP_D   = 4;
    localparam int TAP_E   = 1;

    typedef struct packed {
        logic [LFSR_W-1:0] state;
        logic [KS_MAX-1:0] ks;
    } lfsr_adv_t;

    function automatic lfsr_adv_t lfsr_adv(input logic [LFSR_W-1:0] state, input int nbits);
        lfsr_adv_t         r;
        logic [LFSR_W-1:0] s;
        logic              fb;
        s    = state;
        r.ks = '0;
        for (int k = 0; k < KS_MAX; k++) begin
            if (k < nbits) begin
                r.ks[k] = s[TAP_OUT];
                fb      = s[TAP_OUT] ^ s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D] ^ s[TAP_E];
                s       = {s[LFSR_W-2:0], fb};
            end
        end
        r.state = s;
        return r;
    endfunction

endpackage

// File: rtl/usb4_scr_descr_multilane_lane.sv
// usb4_lfsr_lane: one scrambler/descrambler lane (the operation is its own
// inverse, so the same block serves TX and RX).
// Ports: clk, rst (async, active-low), valid, hold (pass-through, no advance),
// reseed (load SEED before use this cycle), [scr_bypass when USB4_SCR_BYPASS_EN],
// din[DW] (bit 0 first in time), dout[DW] registered, dout_valid registered.
// Optional macro: USB4_SCR_BYPASS_EN adds scr_bypass (data unmodified, LFSR advances).
module usb4_lfsr_lane
    import usb4_scr_pkg::*;
#(
    parameter int                DW   = 1,
    parameter logic [LFSR_W-1:0] SEED = SCR_SEED_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic          hold,
    input  logic          reseed,
`ifdef USB4_SCR_BYPASS_EN
    input  logic          scr_bypass,
`endif
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          dout_valid
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_base;
    logic [DW-1:0]     dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              bypass;
    lfsr_adv_t         adv;
    logic              ks_unused;

`ifdef USB4_SCR_BYPASS_EN
    assign bypass = scr_bypass;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        // Reseed takes effect before this cycle's word is processed.
        lfsr_base    = reseed ? SEED : lfsr_q;
        adv          = lfsr_adv(lfsr_base, DW);
        // Keystream bits beyond DW are always zero; fold them away.
        ks_unused    = ^adv.ks;
        lfsr_d       = lfsr_base;
        dout_d       = dout_q;
        dout_valid_d = valid;
        if (valid) begin
            if (hold) begin
                dout_d = din;
            end else begin
                lfsr_d = adv.state;
                dout_d = bypass ? din : (din ^ adv.ks[DW-1:0]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q       <= SEED;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: rtl/usb4_scr_descr_multilane.sv
// usb4_scr_descr_multilane: LANES TX scramblers and LANES RX descramblers,
// DW bits per lane per clock, 1-clock registered latency.
// Ports: clk, rst (async active-low); TX: tx_valid, tx_hold, scr_rst,
// tx_data/tx_scr [LANES*DW], tx_scr_valid; RX: rx_valid, rx_hold,
// descr_rst[LANES], rx_scr/rx_data [LANES*DW], rx_data_valid.
// Lane i occupies bits [i*DW +: DW].
// Optional macro: USB4_SCR_BYPASS_EN adds input scr_bypass for both paths.
module usb4_scr_descr_multilane
    import usb4_scr_pkg::*;
#(
    parameter int                LANES = 2,
    parameter int                DW    = 1,
    parameter logic [LFSR_W-1:0] SEED  = SCR_SEED_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
`ifdef USB4_SCR_BYPASS_EN
    input  logic                scr_bypass,
`endif
    input  logic                tx_valid,
    input  logic                tx_hold,
    input  logic                scr_rst,
    input  logic [LANES*DW-1:0] tx_data,
    output logic [LANES*DW-1:0] tx_scr,
    output logic                tx_scr_valid,
    input  logic                rx_valid,
    input  logic                rx_hold,
    input  logic [LANES-1:0]    descr_rst,
    input  logic [LANES*DW-1:0] rx_scr,
    output logic [LANES*DW-1:0] rx_data,
    output logic                rx_data_valid
);

    logic [LANES-1:0] tx_lane_valid;
    logic [LANES-1:0] rx_lane_valid;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            usb4_lfsr_lane #(.DW(DW), .SEED(SEED)) u_tx (
                .clk        (clk),
                .rst        (rst),
                .valid      (tx_valid),
                .hold       (tx_hold),
                .reseed     (scr_rst),
`ifdef USB4_SCR_BYPASS_EN
                .scr_bypass (scr_bypass),
`endif
                .din        (tx_data[gi*DW +: DW]),
                .dout       (tx_scr[gi*DW +: DW]),
                .dout_valid (tx_lane_valid[gi])
            );

            usb4_lfsr_lane #(.DW(DW), .SEED(SEED)) u_rx (
                .clk        (clk),
                .rst        (rst),
                .valid      (rx_valid),
                .hold       (rx_hold),
                .reseed     (descr_rst[gi]),
`ifdef USB4_SCR_BYPASS_EN
                .scr_bypass (scr_bypass),
`endif
                .din        (rx_scr[gi*DW +: DW]),
                .dout       (rx_data[gi*DW +: DW]),
                .dout_valid (rx_lane_valid[gi])
            );
        end
    endgenerate

    // Every lane registers the same shared valid, so the per-lane copies are
    // identical; reducing them keeps one consistent output.
    assign tx_scr_valid  = &tx_lane_valid;
    assign rx_data_valid = &rx_lane_valid;

endmodule

// File: doc/usb4_scr_descr_multilane.md
Name: usb4_scr_descr_multilane

Overview:
- Parametrised successor to the bit-serial two-lane scrambler/descrambler pair.
- Scrambles LANES transmit lanes and descrambles LANES receive lanes, DW bits per lane per clock, using the USB4 23-bit LFSR.
- Adds per-lane LFSR state, a hold (skip) input, and a registered valid pipeline.
- Sits between the lane serialiser/deserialiser and the PHY adaptation logic.

Parameters:
- LANES, 2, number of TX lanes and number of RX lanes
- DW, 1, bits per lane per clock (1..32); bit 0 is first in time
- SEED, 23'h1FEEDD, LFSR load value on reset and reseed

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- tx_valid  in  1  TX data valid; advances all TX LFSRs
- tx_hold  in  1  freeze TX LFSRs while tx_valid=1 (ordered-set pass-through)
- scr_rst  in  1  synchronous reseed of all TX LFSRs
- tx_data  in  LANES*DW  lane i occupies bits [i*DW +: DW]
- tx_scr  out  LANES*DW  scrambled TX data
- tx_scr_valid  out  1  registered copy of tx_valid
- rx_valid  in  1  RX data valid; advances RX LFSRs
- rx_hold  in  1  freeze RX LFSRs while rx_valid=1
- descr_rst  in  LANES  per-lane synchronous reseed of RX LFSR
- rx_scr  in  LANES*DW  scrambled RX data
- rx_data  out  LANES*DW  descrambled RX data
- rx_data_valid  out  1  registered copy of rx_valid

Behaviour:
- LFSR step (Fibonacci):
  - out bit = s[22]
  - fb = s[22]^s[20]^s[15]^s[7]^s[4]^s[1]
  - s_next = {s[21:0], fb}
- Per lane, per valid cycle:
  - Bit k (k = 0..DW-1) uses the LFSR after k steps: data[k] ^ outbit_k.
  - The LFSR then advances DW steps.
  - Implement as an unrolled combinational loop, not DW clocks.
- hold=1 with valid=1:
  - Data passes through unscrambled (out = in).
  - LFSR does not advance.
- valid=0:
  - LFSR holds.
  - Data output holds its previous value.
  - Output valid = 0.
- Latency: 1 clock from input to data/valid outputs; both are registered.
- rst asserted (low):
  - Every LFSR = SEED.
  - tx_scr, rx_data = 0.
  - tx_scr_valid, rx_data_valid = 0.
  - Takes effect immediately, including mid-stream.
- scr_rst=1:
  - All TX LFSRs load SEED at the clock edge.
  - If tx_valid=1 in the same cycle, that word is scrambled with SEED (reseed-then-use), and the LFSR ends the cycle at SEED advanced DW steps.
  - Same rule applies to descr_rst[i] for RX lane i only; other lanes are unaffected.
- reseed and hold in the same cycle: the LFSR loads SEED, the word passes through unscrambled, and there is no advance.
- All TX lanes share identical LFSR sequences; RX lanes are independent after a per-lane reseed.
- Sequence is continuous across words: the sequence for DW=8 must equal the DW=1 sequence concatenated.

Optional Feature:
- Macro: USB4_SCR_BYPASS_EN
- With the macro:
  - Adds input scr_bypass (1 bit), sampled each clock.
  - When scr_bypass=1, both paths pass data through unmodified while LFSRs continue to advance as normal, so re-enabling stays in sync with the link partner.
- Without the macro: no port, and the scrambler is always active.

Decomposition:
- Package usb4_scr_pkg:
  - LFSR_W = 23
  - SCR_SEED_DEFAULT = 23'h1FEEDD
  - tap index constants
  - function lfsr_adv(state, nbits) returning next state and keystream vector
- Sub-module usb4_lfsr_lane:
  - Ports: clk, rst, valid, hold, reseed, din[DW], dout[DW], dout_valid.
  - Instantiated LANES times for TX and LANES times for RX.
  - Top level is generate loops plus valid registers.

Test Plan:
- Reset, DW=1, tx_valid=1, tx_data=0 for 3 clocks -> tx_scr sequence 0,0,1 (SEED bits 22, 21, 20), tx_scr_valid rises 1 clock after tx_valid.
- Loopback tx_scr -> rx_scr, 1000 random words, DW=8, LANES=2 -> rx_data equals tx_data delayed 2 clocks, zero mismatches.
- DW=8 vs DW=1 runs from reset with zero input -> DW=8 word n equals DW=1 bits 8n..8n+7.
- tx_hold=1 for 4 words inside a stream, tx_data=8'hA5 -> tx_scr=8'hA5 for those words; loopback with rx_hold aligned still matches afterwards.
- descr_rst[1]=1 mid-stream with rx_valid=1 -> lane 1 keystream restarts at SEED that cycle, lane 0 unaffected; rst low mid-stream -> all outputs 0 next sample.
- USB4_SCR_BYPASS_EN: scr_bypass=1 for 10 words, then 0 -> bypassed words equal input; the next word matches the keystream of an uninterrupted run.
